// File: rtl/atmega_tim_prescaler_pkg.sv
// Shared constants for the ATmega 8-bit timer prescaler and the timers that consume its taps.
// GTCCR bit positions and prescaler tap bit indices live here so every timer agrees on them.
package atmega_tim_prescaler_pkg;

  localparam int CNT_W = 10;

  // GTCCR bit positions
  localparam int GTCCR_PSRSYNC = 0;
  localparam int GTCCR_PSRASY  = 1;
  localparam int GTCCR_TSM     = 7;

  // Prescaler counter bit that forms each divided tap (rises at N/2, period N)
  localparam int TAP_CLK8    = 2;
  localparam int TAP_CLK32   = 4;
  localparam int TAP_CLK64   = 5;
  localparam int TAP_CLK128  = 6;
  localparam int TAP_CLK256  = 7;
  localparam int TAP_CLK1024 = 9;

endpackage

// File: rtl/atmega_presc_cnt.sv
// 10-bit free-running prescaler counter. While clr_i is high the counter is
// forced to zero on every clock edge; otherwise it increments and wraps with no gap.
module atmega_presc_cnt
  import atmega_tim_prescaler_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: hold at zero while cleared, else increment (natural wrap at 10'h3FF)
  always_comb begin
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    if (clr_i) begin
      cnt_d = '0;
    end
  end

  // Counter register with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/atmega_tim_prescaler.sv
// Shared upstream stage for the ATmega 8-bit timers: GTCCR register, synchronous
// prescaler taps, external T pin synchroniser with edge pulses.
// Optional second (asynchronous-timer style) prescaler controlled by PSRASY is
// built when ATMEGA_TIM_PRESC_ASY_EN is defined; otherwise asy_clk_o is 0 and
// GTCCR[1] is read-only zero.
module atmega_tim_prescaler
  import atmega_tim_prescaler_pkg::*;
#(
  parameter int                           BUS_ADDR_DATA_LEN = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] GTCCR_ADDR        = BUS_ADDR_DATA_LEN'('h43),
  parameter int                           T_SYNC_STAGES     = 2   // must be >= 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
  input  logic                         wr_i,
  input  logic                         rd_i,
  input  logic [7:0]                   bus_i,
  output logic [7:0]                   bus_o,
  output logic                         clk8_o,
  output logic                         clk64_o,
  output logic                         clk256_o,
  output logic                         clk1024_o,
  input  logic                         t_i,
  output logic                         t_rise_o,
  output logic                         t_fall_o,
  output logic [5:0]                   asy_clk_o
);

  logic             gtccr_wr;
  logic             tsm_q, tsm_d;
  logic             psrsync_q, psrsync_d;
  logic             psrasy_bit;
  logic [CNT_W-1:0] cnt;

  assign gtccr_wr = wr_i && (addr_i == GTCCR_ADDR);

  // GTCCR next state: software may only set the reset bits; hardware drops
  // PSRSYNC one cycle later unless TSM holds it
  always_comb begin
    tsm_d     = tsm_q;
    psrsync_d = psrsync_q;
    if (psrsync_q && !tsm_q) begin
      psrsync_d = 1'b0;
    end
    if (gtccr_wr) begin
      tsm_d = bus_i[GTCCR_TSM];
      if (bus_i[GTCCR_PSRSYNC]) begin
        psrsync_d = 1'b1;
      end
    end
  end

  // GTCCR storage
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tsm_q     <= 1'b0;
      psrsync_q <= 1'b0;
    end else begin
      tsm_q     <= tsm_d;
      psrsync_q <= psrsync_d;
    end
  end

  atmega_presc_cnt u_sync_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (psrsync_q),
    .cnt_o (cnt)
  );

  assign clk8_o    = cnt[TAP_CLK8];
  assign clk64_o   = cnt[TAP_CLK64];
  assign clk256_o  = cnt[TAP_CLK256];
  assign clk1024_o = cnt[TAP_CLK1024];

`ifdef ATMEGA_TIM_PRESC_ASY_EN
  logic             psrasy_q, psrasy_d;
  logic [CNT_W-1:0] asy_cnt;
  logic             unused_asy_cnt;

  // PSRASY follows the same set/auto-clear/TSM-hold rules as PSRSYNC
  always_comb begin
    psrasy_d = psrasy_q;
    if (psrasy_q && !tsm_q) begin
      psrasy_d = 1'b0;
    end
    if (gtccr_wr && bus_i[GTCCR_PSRASY]) begin
      psrasy_d = 1'b1;
    end
  end

  // PSRASY storage
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      psrasy_q <= 1'b0;
    end else begin
      psrasy_q <= psrasy_d;
    end
  end

  atmega_presc_cnt u_asy_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (psrasy_q),
    .cnt_o (asy_cnt)
  );

  assign psrasy_bit     = psrasy_q;
  assign asy_clk_o      = {asy_cnt[TAP_CLK1024], asy_cnt[TAP_CLK256], asy_cnt[TAP_CLK128],
                           asy_cnt[TAP_CLK64], asy_cnt[TAP_CLK32], asy_cnt[TAP_CLK8]};
  assign unused_asy_cnt = ^{asy_cnt[8], asy_cnt[3], asy_cnt[1:0]};
`else
  logic unused_asy_bit;

  assign psrasy_bit     = 1'b0;
  assign asy_clk_o      = 6'h00;
  assign unused_asy_bit = bus_i[GTCCR_PSRASY];
`endif

  // Bits 6:2 of GTCCR are unimplemented; low counter bits are not tapped here
  logic unused_bits;
  assign unused_bits = ^{bus_i[6:2], cnt[8], cnt[6], cnt[4:3], cnt[1:0]};

  // Combinational register read
  always_comb begin
    bus_o = 8'h00;
    if (rd_i && (addr_i == GTCCR_ADDR)) begin
      bus_o = {tsm_q, 5'b00000, psrasy_bit, psrsync_q};
    end
  end

  // T pin synchroniser. A parallel valid chain marks when the last stage holds
  // a real pin sample, so the first sample after reset never looks like an edge.
  logic [T_SYNC_STAGES-1:0] sync_q, sync_d;
  logic [T_SYNC_STAGES-1:0] svld_q, svld_d;
  logic                     prev_q, prev_d;
  logic                     t_vld_q, t_vld_d;
  logic                     rise_q, rise_d;
  logic                     fall_q, fall_d;
  logic                     t_s;
  logic                     t_s_vld;

  assign t_s     = sync_q[T_SYNC_STAGES-1];
  assign t_s_vld = svld_q[T_SYNC_STAGES-1];

  // Synchroniser shift, previous-value capture and registered edge pulses
  always_comb begin
    sync_d  = {sync_q[T_SYNC_STAGES-2:0], t_i};
    svld_d  = {svld_q[T_SYNC_STAGES-2:0], 1'b1};
    prev_d  = t_s;
    t_vld_d = t_s_vld;
    rise_d  = t_s_vld && t_vld_q && t_s && !prev_q;
    fall_d  = t_s_vld && t_vld_q && !t_s && prev_q;
  end

  // Synchroniser and pulse registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q  <= '0;
      svld_q  <= '0;
      prev_q  <= 1'b0;
      t_vld_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      svld_q  <= svld_d;
      prev_q  <= prev_d;
      t_vld_q <= t_vld_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign t_rise_o = rise_q;
  assign t_fall_o = fall_q;

endmodule

// File: tb/tb_atmega_tim_prescaler.sv
// Self-checking bench for atmega_tim_prescaler. Expected values are pushed to a
// scoreboard queue as stimulus is applied and popped after each clock edge.
// Build with +define+ATMEGA_TIM_PRESC_ASY_EN to exercise the second prescaler.
module tb_atmega_tim_prescaler;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [7:0] addr_i = 8'h43;
  logic       wr_i = 1'b0;
  logic       rd_i = 1'b0;
  logic [7:0] bus_i = 8'h00;
  logic [7:0] bus_o;
  logic       clk8_o, clk64_o, clk256_o, clk1024_o;
  logic       t_i = 1'b0;
  logic       t_rise_o, t_fall_o;
  logic [5:0] asy_clk_o;

  typedef struct packed {
    logic [3:0] taps;
    logic [5:0] asy;
    logic       rise;
    logic       fall;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  atmega_tim_prescaler dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .addr_i    (addr_i),
    .wr_i      (wr_i),
    .rd_i      (rd_i),
    .bus_i     (bus_i),
    .bus_o     (bus_o),
    .clk8_o    (clk8_o),
    .clk64_o   (clk64_o),
    .clk256_o  (clk256_o),
    .clk1024_o (clk1024_o),
    .t_i       (t_i),
    .t_rise_o  (t_rise_o),
    .t_fall_o  (t_fall_o),
    .asy_clk_o (asy_clk_o)
  );

  always #5 clk_i = ~clk_i;

  wire [3:0] taps_obs = {clk1024_o, clk256_o, clk64_o, clk8_o};

  // Tap levels {clk1024, clk256, clk64, clk8} for a given counter value
  function automatic logic [3:0] taps_of(int c);
    logic [9:0] v;
    v = c[9:0];
    return {v[9], v[7], v[5], v[2]};
  endfunction

  // asy taps {1024,256,128,64,32,8} for a given counter value
  function automatic logic [5:0] asy_of(int c);
    logic [9:0] v;
    v = c[9:0];
    return {v[9], v[7], v[6], v[5], v[4], v[2]};
  endfunction

  // One clock edge; returns at the following falling edge for sampling/driving
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic advance(int n);
    for (int i = 0; i < n; i++) step();
    exp_cnt += n;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; t_i = 1'b0; wr_i = 1'b0; rd_i = 1'b1; addr_i = 8'h43; bus_i = 8'h00;
    step();
    n_vec++;
    if ({taps_obs, asy_clk_o, t_rise_o, t_fall_o} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_outputs got=%b want=%b", {taps_obs, asy_clk_o, t_rise_o, t_fall_o}, 12'h000);
    end
    n_vec++;
    if (bus_o !== 8'h00) begin
      n_err++;
      $display("FAIL reset_gtccr got=%h want=00", bus_o);
    end
    rst_i = 1'b1;
    exp_cnt = 0;
    $display("reset: outputs and GTCCR checked, reset released");
  endtask

  task automatic test_idle();
    exp_t e;
    rd_i = 1'b0;
    for (int c = 1; c <= 1030; c++)
      sb_q.push_back(exp_t'{taps: taps_of(c), asy: 6'h00, rise: 1'b0, fall: 1'b0});
    for (int c = 1; c <= 1030; c++) begin
      step();
      e = sb_q.pop_front();
      n_vec++;
      if (taps_obs !== e.taps) begin
        n_err++;
        $display("FAIL idle_taps cyc=%0d got=%b want=%b", c, taps_obs, e.taps);
      end
      n_vec++;
      if (bus_o !== 8'h00) begin
        n_err++;
        $display("FAIL idle_bus_no_rd cyc=%0d got=%h want=00", c, bus_o);
      end
    end
    exp_cnt = 1030;
    $display("idle: 1030 cycles of tap levels checked");
  endtask

  task automatic test_psrsync();
    exp_t e;
    advance((12'h123 - (exp_cnt % 1024) + 1024) % 1024);
    sb_q.push_back(exp_t'{taps: taps_of(12'h124), asy: 6'h00, rise: 1'b0, fall: 1'b0});
    for (int c = 0; c <= 8; c++)
      sb_q.push_back(exp_t'{taps: taps_of(c), asy: 6'h00, rise: 1'b0, fall: 1'b0});
    addr_i = 8'h43; bus_i = 8'h01; wr_i = 1'b1; rd_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      wr_i = 1'b0;
      e = sb_q.pop_front();
      n_vec++;
      if (taps_obs !== e.taps) begin
        n_err++;
        $display("FAIL psrsync_taps step=%0d got=%b want=%b", i, taps_obs, e.taps);
      end
      if (i == 0) begin
        n_vec++;
        if (bus_o !== 8'h01) begin
          n_err++;
          $display("FAIL psrsync_set_read got=%h want=01", bus_o);
        end
      end
      if (i == 1) begin
        n_vec++;
        if (bus_o !== 8'h00) begin
          n_err++;
          $display("FAIL psrsync_autoclear_read got=%h want=00", bus_o);
        end
      end
    end
    exp_cnt = 8;
    $display("psrsync: write 01 at cnt=123, one-cycle clear checked");
  endtask

  task automatic test_tsm();
    exp_t e;
    sb_q.push_back(exp_t'{taps: taps_of(exp_cnt + 1), asy: 6'h00, rise: 1'b0, fall: 1'b0});
    for (int i = 0; i < 100; i++)
      sb_q.push_back(exp_t'{taps: 4'h0, asy: 6'h00, rise: 1'b0, fall: 1'b0});
    bus_i = 8'h81; wr_i = 1'b1; rd_i = 1'b1;
    for (int i = 0; i < 101; i++) begin
      step();
      wr_i = 1'b0;
      e = sb_q.pop_front();
      n_vec++;
      if (taps_obs !== e.taps) begin
        n_err++;
        $display("FAIL tsm_hold_taps step=%0d got=%b want=%b", i, taps_obs, e.taps);
      end
    end
    n_vec++;
    if (bus_o !== 8'h81) begin
      n_err++;
      $display("FAIL tsm_hold_read got=%h want=81", bus_o);
    end
    // Release: counter stays 0 through the PSRSYNC auto-clear cycle, then counts
    sb_q.push_back(exp_t'{taps: 4'h0, asy: 6'h00, rise: 1'b0, fall: 1'b0});
    for (int c = 0; c <= 7; c++)
      sb_q.push_back(exp_t'{taps: taps_of(c), asy: 6'h00, rise: 1'b0, fall: 1'b0});
    bus_i = 8'h00; wr_i = 1'b1;
    for (int j = 0; j < 9; j++) begin
      step();
      wr_i = 1'b0;
      e = sb_q.pop_front();
      n_vec++;
      if (taps_obs !== e.taps) begin
        n_err++;
        $display("FAIL tsm_release_taps step=%0d got=%b want=%b", j, taps_obs, e.taps);
      end
      if (j == 1) begin
        n_vec++;
        if (bus_o !== 8'h00) begin
          n_err++;
          $display("FAIL tsm_release_read got=%h want=00", bus_o);
        end
      end
    end
    exp_cnt = 7;
    $display("tsm: 100-cycle halt and release checked");
  endtask

  task automatic test_reserved_bits();
    exp_t e;
    sb_q.push_back(exp_t'{taps: taps_of(exp_cnt + 1), asy: 6'h00, rise: 1'b0, fall: 1'b0});
    bus_i = 8'hFC; wr_i = 1'b1; rd_i = 1'b1;
    step();
    wr_i = 1'b0;
    e = sb_q.pop_front();
    n_vec++;
    if (taps_obs !== e.taps) begin
      n_err++;
      $display("FAIL reserved_taps got=%b want=%b", taps_obs, e.taps);
    end
    n_vec++;
    if (bus_o !== 8'h80) begin
      n_err++;
      $display("FAIL reserved_read got=%h want=80", bus_o);
    end
    bus_i = 8'h00; wr_i = 1'b1;
    step();
    wr_i = 1'b0;
    n_vec++;
    if (bus_o !== 8'h00) begin
      n_err++;
      $display("FAIL reserved_clear_read got=%h want=00", bus_o);
    end
    exp_cnt += 2;
    $display("reserved: write FC reads 80, bits 6:2 ignored");
  endtask

  task automatic test_t_edges();
    exp_t e;
    rst_i = 1'b0; t_i = 1'b1;
    step();
    rst_i = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 20; i++)
      sb_q.push_back(exp_t'{taps: 4'h0, asy: 6'h00, rise: 1'b0, fall: 1'b0});
    for (int i = 0; i < 10; i++)
      sb_q.push_back(exp_t'{taps: 4'h0, asy: 6'h00, rise: 1'b0, fall: (i == 2)});
    for (int i = 0; i < 10; i++)
      sb_q.push_back(exp_t'{taps: 4'h0, asy: 6'h00, rise: (i == 2), fall: 1'b0});
    for (int i = 0; i < 40; i++) begin
      if (i == 20) t_i = 1'b0;
      if (i == 30) t_i = 1'b1;
      step();
      e = sb_q.pop_front();
      n_vec++;
      if ({t_rise_o, t_fall_o} !== {e.rise, e.fall}) begin
        n_err++;
        $display("FAIL t_edge step=%0d got rise/fall=%b%b want=%b%b", i, t_rise_o, t_fall_o, e.rise, e.fall);
      end
    end
    exp_cnt = 40;
    $display("t_pin: held-high reset release and 1->0->1 edges checked");
  endtask

  task automatic test_async_reset();
    exp_t e;
    advance((12'h2AA - (exp_cnt % 1024) + 1024) % 1024);
    bus_i = 8'h81; wr_i = 1'b1; rd_i = 1'b1;
    step();
    wr_i = 1'b0;
    n_vec++;
    if (taps_obs !== taps_of(12'h2AB)) begin
      n_err++;
      $display("FAIL areset_pre_taps got=%b want=%b", taps_obs, taps_of(12'h2AB));
    end
    n_vec++;
    if (bus_o !== 8'h81) begin
      n_err++;
      $display("FAIL areset_pre_read got=%h want=81", bus_o);
    end
    #2 rst_i = 1'b0;
    #1;
    n_vec++;
    if ({taps_obs, asy_clk_o, t_rise_o, t_fall_o} !== 12'h000) begin
      n_err++;
      $display("FAIL areset_outputs got=%b want=%b", {taps_obs, asy_clk_o, t_rise_o, t_fall_o}, 12'h000);
    end
    n_vec++;
    if (bus_o !== 8'h00) begin
      n_err++;
      $display("FAIL areset_gtccr got=%h want=00", bus_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int c = 1; c <= 4; c++)
      sb_q.push_back(exp_t'{taps: taps_of(c), asy: 6'h00, rise: 1'b0, fall: 1'b0});
    for (int c = 1; c <= 4; c++) begin
      step();
      e = sb_q.pop_front();
      n_vec++;
      if (taps_obs !== e.taps) begin
        n_err++;
        $display("FAIL areset_restart_taps cyc=%0d got=%b want=%b", c, taps_obs, e.taps);
      end
    end
    exp_cnt = 4;
    $display("async_reset: mid-count clear without clock edge checked");
  endtask

  task automatic test_asy();
    exp_t e;
    logic [7:0] want_set;
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    exp_cnt = 0;
    advance(300);
`ifdef ATMEGA_TIM_PRESC_ASY_EN
    want_set = 8'h02;
    sb_q.push_back(exp_t'{taps: taps_of(301), asy: asy_of(301), rise: 1'b0, fall: 1'b0});
    for (int j = 1; j < 20; j++)
      sb_q.push_back(exp_t'{taps: taps_of(301 + j), asy: asy_of(j - 1), rise: 1'b0, fall: 1'b0});
`else
    want_set = 8'h00;
    for (int j = 0; j < 20; j++)
      sb_q.push_back(exp_t'{taps: taps_of(301 + j), asy: 6'h00, rise: 1'b0, fall: 1'b0});
`endif
    bus_i = 8'h02; wr_i = 1'b1; rd_i = 1'b1;
    for (int j = 0; j < 20; j++) begin
      step();
      wr_i = 1'b0;
      e = sb_q.pop_front();
      n_vec++;
      if (taps_obs !== e.taps) begin
        n_err++;
        $display("FAIL asy_sync_taps step=%0d got=%b want=%b", j, taps_obs, e.taps);
      end
      n_vec++;
      if (asy_clk_o !== e.asy) begin
        n_err++;
        $display("FAIL asy_taps step=%0d got=%b want=%b", j, asy_clk_o, e.asy);
      end
      if (j == 0) begin
        n_vec++;
        if (bus_o !== want_set) begin
          n_err++;
          $display("FAIL asy_set_read got=%h want=%h", bus_o, want_set);
        end
      end
      if (j == 1) begin
        n_vec++;
        if (bus_o !== 8'h00) begin
          n_err++;
          $display("FAIL asy_clear_read got=%h want=00", bus_o);
        end
      end
    end
    exp_cnt = 320;
    $display("asy: write 02 checked against sync and asy taps");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_psrsync();
    test_tsm();
    test_reserved_bits();
    test_t_edges();
    test_async_reset();
    test_asy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
